// File: rtl/ex_operand_stage.sv
// EX operand stage: ID->EX pipeline register, operand forwarding and hazard stall control.
// Optional feature macro: FORWARDING_EN (MEM/WB result bypass; otherwise stall on every RAW hazard).
module ex_operand_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        ID_VALID,
  output logic        ID_READY,
  input  logic [4:0]  ID_RS1_ADDR,
  input  logic [4:0]  ID_RS2_ADDR,
  input  logic [31:0] ID_RS1_DATA,
  input  logic [31:0] ID_RS2_DATA,
  input  logic [31:0] ID_IMM,
  input  logic        ID_USE_IMM,
  input  logic [2:0]  ID_CTRL,
  input  logic [4:0]  ID_RD_ADDR,
  input  logic        ID_REG_WRITE,
  input  logic        ID_MEM_READ,
  input  logic [4:0]  MEM_RD_ADDR,
  input  logic        MEM_REG_WRITE,
  input  logic [31:0] MEM_RESULT,
  input  logic [4:0]  WB_RD_ADDR,
  input  logic        WB_REG_WRITE,
  input  logic [31:0] WB_RESULT,
  output logic [31:0] DATA_A,
  output logic [31:0] DATA_B,
  output logic [2:0]  CTRL,
  output logic        EX_VALID,
  output logic [4:0]  EX_RD_ADDR,
  output logic        EX_REG_WRITE,
  output logic        EX_MEM_READ,
  output logic [15:0] STALL_CNT
);

  logic        valid_q, valid_d;
  logic [4:0]  rs1_addr_q, rs1_addr_d;
  logic [4:0]  rs2_addr_q, rs2_addr_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [31:0] rs2_data_q, rs2_data_d;
  logic [31:0] imm_q, imm_d;
  logic        use_imm_q, use_imm_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        ex_hazard;
  logic        stall;
  logic        id_ready;
  logic        accept;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  // x0 never counts as a source or destination of a hazard.
  function automatic logic src_hit(input logic [4:0] src, input logic wr_en,
                                   input logic [4:0] wr_addr);
    return (src != 5'd0) && wr_en && (src == wr_addr);
  endfunction

  always_comb begin
    ex_hazard = src_hit(ID_RS1_ADDR, valid_q & reg_write_q, rd_addr_q) |
                src_hit(ID_RS2_ADDR, valid_q & reg_write_q, rd_addr_q);
`ifdef FORWARDING_EN
    stall = ex_hazard & mem_read_q;
`else
    stall = ex_hazard |
            src_hit(ID_RS1_ADDR, MEM_REG_WRITE, MEM_RD_ADDR) |
            src_hit(ID_RS2_ADDR, MEM_REG_WRITE, MEM_RD_ADDR) |
            src_hit(ID_RS1_ADDR, WB_REG_WRITE, WB_RD_ADDR) |
            src_hit(ID_RS2_ADDR, WB_REG_WRITE, WB_RD_ADDR);
`endif
    if (RST) begin
      id_ready = 1'b0;
    end else if (FLUSH) begin
      id_ready = 1'b1;
    end else begin
      id_ready = ~stall;
    end
    accept = ID_VALID & id_ready & ~FLUSH;
  end

  // Anything not accepted becomes a fully zeroed bubble.
  always_comb begin
    valid_d     = 1'b0;
    rs1_addr_d  = 5'd0;
    rs2_addr_d  = 5'd0;
    rs1_data_d  = 32'd0;
    rs2_data_d  = 32'd0;
    imm_d       = 32'd0;
    use_imm_d   = 1'b0;
    ctrl_d      = 3'd0;
    rd_addr_d   = 5'd0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    if (accept) begin
      valid_d     = 1'b1;
      rs1_addr_d  = ID_RS1_ADDR;
      rs2_addr_d  = ID_RS2_ADDR;
      rs1_data_d  = ID_RS1_DATA;
      rs2_data_d  = ID_RS2_DATA;
      imm_d       = ID_IMM;
      use_imm_d   = ID_USE_IMM;
      ctrl_d      = ID_CTRL;
      rd_addr_d   = ID_RD_ADDR;
      reg_write_d = ID_REG_WRITE;
      mem_read_d  = ID_MEM_READ;
    end
    stall_cnt_d = stall_cnt_q;
    if (ID_VALID && !id_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= 5'd0;
      rs2_addr_q  <= 5'd0;
      rs1_data_q  <= 32'd0;
      rs2_data_q  <= 32'd0;
      imm_q       <= 32'd0;
      use_imm_q   <= 1'b0;
      ctrl_q      <= 3'd0;
      rd_addr_q   <= 5'd0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      valid_q     <= valid_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      ctrl_q      <= ctrl_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef FORWARDING_EN
  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    rs1_fwd = rs1_data_q;
    if (src_hit(rs1_addr_q, MEM_REG_WRITE, MEM_RD_ADDR)) begin
      rs1_fwd = MEM_RESULT;
    end else if (src_hit(rs1_addr_q, WB_REG_WRITE, WB_RD_ADDR)) begin
      rs1_fwd = WB_RESULT;
    end
    rs2_fwd = rs2_data_q;
    if (src_hit(rs2_addr_q, MEM_REG_WRITE, MEM_RD_ADDR)) begin
      rs2_fwd = MEM_RESULT;
    end else if (src_hit(rs2_addr_q, WB_REG_WRITE, WB_RD_ADDR)) begin
      rs2_fwd = WB_RESULT;
    end
  end
`else
  logic unused_no_fwd;
  assign unused_no_fwd = ^{MEM_RESULT, WB_RESULT, rs1_addr_q, rs2_addr_q};
  assign rs1_fwd = rs1_data_q;
  assign rs2_fwd = rs2_data_q;
`endif

  assign ID_READY     = id_ready;
  assign DATA_A       = rs1_fwd;
  assign DATA_B       = use_imm_q ? imm_q : rs2_fwd;
  assign CTRL         = ctrl_q;
  assign EX_VALID     = valid_q;
  assign EX_RD_ADDR   = rd_addr_q;
  assign EX_REG_WRITE = reg_write_q;
  assign EX_MEM_READ  = mem_read_q;
  assign STALL_CNT    = stall_cnt_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed scoreboard bench for ex_operand_stage; FORWARDING_EN selects the matching expectations.
module tb_ex_operand_stage;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, ID_VALID, ID_READY;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
  logic [31:0] ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic        ID_USE_IMM, ID_REG_WRITE, ID_MEM_READ;
  logic [2:0]  ID_CTRL;
  logic [4:0]  MEM_RD_ADDR, WB_RD_ADDR;
  logic        MEM_REG_WRITE, WB_REG_WRITE;
  logic [31:0] MEM_RESULT, WB_RESULT;
  logic [31:0] DATA_A, DATA_B;
  logic [2:0]  CTRL;
  logic        EX_VALID, EX_REG_WRITE, EX_MEM_READ;
  logic [4:0]  EX_RD_ADDR;
  logic [15:0] STALL_CNT;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 CLK = ~CLK;

  ex_operand_stage dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .ID_VALID(ID_VALID), .ID_READY(ID_READY),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA),
    .ID_IMM(ID_IMM), .ID_USE_IMM(ID_USE_IMM), .ID_CTRL(ID_CTRL),
    .ID_RD_ADDR(ID_RD_ADDR), .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ),
    .MEM_RD_ADDR(MEM_RD_ADDR), .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_RESULT(MEM_RESULT),
    .WB_RD_ADDR(WB_RD_ADDR), .WB_REG_WRITE(WB_REG_WRITE), .WB_RESULT(WB_RESULT),
    .DATA_A(DATA_A), .DATA_B(DATA_B), .CTRL(CTRL), .EX_VALID(EX_VALID),
    .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ),
    .STALL_CNT(STALL_CNT)
  );

  typedef struct {
    string       tag;
    bit          bubble;
    logic        valid;
    logic [31:0] a, b;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic        rw, mr;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_full(input string tag, input bit bubble, input logic valid,
                           input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl,
                           input logic [4:0] rd, input logic rw, input logic mr);
    exp_t e;
    e.tag = tag; e.bubble = bubble; e.valid = valid; e.a = a; e.b = b;
    e.ctrl = ctrl; e.rd = rd; e.rw = rw; e.mr = mr; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic push_ex(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctrl, input logic [4:0] rd, input logic rw,
                         input logic mr);
    push_full(tag, 1'b0, 1'b1, a, b, ctrl, rd, rw, mr);
  endtask

  task automatic push_bubble(input string tag, input bit stalled);
    if (stalled && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    push_full(tag, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".valid"}, {31'd0, EX_VALID}, {31'd0, e.valid});
      check({e.tag, ".ctrl"}, {29'd0, CTRL}, {29'd0, e.ctrl});
      check({e.tag, ".reg_write"}, {31'd0, EX_REG_WRITE}, {31'd0, e.rw});
      check({e.tag, ".mem_read"}, {31'd0, EX_MEM_READ}, {31'd0, e.mr});
      check({e.tag, ".stall_cnt"}, {16'd0, STALL_CNT}, {16'd0, e.cnt});
      if (!e.bubble) begin
        check({e.tag, ".data_a"}, DATA_A, e.a);
        check({e.tag, ".data_b"}, DATA_B, e.b);
        check({e.tag, ".rd"}, {27'd0, EX_RD_ADDR}, {27'd0, e.rd});
      end
      $display("txn %s: valid=%0b a=0x%0h b=0x%0h ctrl=%0d rd=%0d stall_cnt=%0d",
               e.tag, EX_VALID, DATA_A, DATA_B, CTRL, EX_RD_ADDR, STALL_CNT);
    end
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    check({tag, ".id_ready"}, {31'd0, ID_READY}, {31'd0, exp});
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                          input logic use_imm, input logic [2:0] ctrl, input logic [4:0] rd,
                          input logic rw, input logic mr);
    ID_VALID = v; ID_RS1_ADDR = rs1; ID_RS1_DATA = d1; ID_RS2_ADDR = rs2; ID_RS2_DATA = d2;
    ID_IMM = imm; ID_USE_IMM = use_imm; ID_CTRL = ctrl; ID_RD_ADDR = rd;
    ID_REG_WRITE = rw; ID_MEM_READ = mr;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    MEM_RD_ADDR = rd; MEM_REG_WRITE = rw; MEM_RESULT = res;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic rw, input logic [31:0] res);
    WB_RD_ADDR = rd; WB_REG_WRITE = rw; WB_RESULT = res;
  endtask

  initial begin
    RST = 1'b1;
    FLUSH = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_mem(0, 0, 0);
    set_wb(0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;

    // Reset holds ID_READY low even with a valid offer
    drive_id(1, 5'd1, 32'd5, 5'd2, 32'd7, 0, 0, 3'd5, 5'd6, 1, 0);
    check_ready("reset", 1'b0);
    push_full("reset", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    tick();

    RST = 1'b0;
    drive_id(1, 5'd1, 32'd5, 5'd2, 32'd7, 0, 0, 3'd0, 5'd5, 1, 0);
    check_ready("add", 1'b1);
    push_ex("add", 32'd5, 32'd7, 3'd0, 5'd5, 1, 0);
    tick();

    drive_id(1, 5'd3, 32'h100, 5'd6, 32'h999, 32'hFFFF_FFF0, 1, 3'd2, 5'd7, 1, 0);
    check_ready("imm", 1'b1);
    push_ex("imm", 32'h100, 32'hFFFF_FFF0, 3'd2, 5'd7, 1, 0);
    tick();

    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_ready("idle", 1'b1);
    push_bubble("idle", 0);
    tick();

    // Load followed by a dependent instruction: one stall cycle
    drive_id(1, 5'd2, 32'h40, 5'd0, 0, 32'd8, 1, 3'd0, 5'd4, 1, 1);
    check_ready("load", 1'b1);
    push_ex("load", 32'h40, 32'd8, 3'd0, 5'd4, 1, 1);
    tick();

    drive_id(1, 5'd4, 32'h11, 5'd1, 32'h22, 0, 0, 3'd1, 5'd8, 1, 0);
    check_ready("lu_stall", 1'b0);
    push_bubble("lu_stall", 1);
    tick();

    check_ready("lu_accept", 1'b1);
    push_ex("lu_accept", 32'h11, 32'h22, 3'd1, 5'd8, 1, 0);
    tick();

    // Flush arriving during a load-use stall
    drive_id(1, 5'd1, 32'd3, 5'd0, 0, 32'd4, 1, 3'd0, 5'd9, 1, 1);
    check_ready("load2", 1'b1);
    push_ex("load2", 32'd3, 32'd4, 3'd0, 5'd9, 1, 1);
    tick();

    drive_id(1, 5'd9, 32'h55, 5'd0, 0, 0, 0, 3'd0, 5'd10, 1, 0);
    check_ready("pre_flush", 1'b0);
    FLUSH = 1'b1;
    check_ready("flush", 1'b1);
    push_bubble("flush", 0);
    tick();

    FLUSH = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_ready("post_flush", 1'b1);
    push_bubble("post_flush", 0);
    tick();

    // x0 writers in MEM/WB never stall and never forward
    set_mem(5'd0, 1, 32'hDEAD);
    set_wb(5'd0, 1, 32'hBEEF);
    drive_id(1, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0, 3'd4, 5'd10, 1, 0);
    check_ready("x0", 1'b1);
    push_ex("x0", 32'd0, 32'd0, 3'd4, 5'd10, 1, 0);
    tick();

    set_mem(0, 0, 0);
    set_wb(0, 0, 0);
    drive_id(1, 5'd3, 32'h77, 5'd0, 0, 0, 0, 3'd0, 5'd12, 1, 0);
    check_ready("rs3", 1'b1);
    push_ex("rs3", 32'h77, 32'd0, 3'd0, 5'd12, 1, 0);
    tick();

    // Operand A with MEM and WB both writing x3, then WB only, then neither
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_mem(5'd3, 1, 32'h10);
    set_wb(5'd3, 1, 32'h20);
    #1;
    check("fwd_mem_wins", DATA_A, FWD ? 32'h10 : 32'h77);
    set_mem(5'd3, 0, 32'h10);
    #1;
    check("fwd_wb", DATA_A, FWD ? 32'h20 : 32'h77);
    set_wb(5'd3, 0, 32'h20);
    #1;
    check("fwd_none", DATA_A, 32'h77);
    push_bubble("idle2", 0);
    tick();

`ifndef FORWARDING_EN
    drive_id(1, 0, 0, 0, 0, 0, 0, 3'd0, 5'd13, 1, 0);
    push_ex("w13", 32'd0, 32'd0, 3'd0, 5'd13, 1, 0);
    tick();

    drive_id(1, 5'd13, 32'd1, 5'd0, 0, 0, 0, 3'd0, 5'd14, 1, 0);
    check_ready("ex_haz", 1'b0);
    push_bubble("ex_haz", 1);
    tick();

    set_mem(5'd13, 1, 32'h1234);
    check_ready("mem_haz", 1'b0);
    push_bubble("mem_haz", 1);
    tick();

    set_mem(0, 0, 0);
    set_wb(5'd13, 1, 32'h5678);
    check_ready("wb_haz", 1'b0);
    push_bubble("wb_haz", 1);
    tick();

    set_wb(0, 0, 0);
    check_ready("haz_accept", 1'b1);
    push_ex("haz_accept", 32'd1, 32'd0, 3'd0, 5'd14, 1, 0);
    tick();

    // Hold a MEM hazard long enough to saturate the stall counter
    set_mem(5'd13, 1, 32'h1234);
    begin
      int n_cycles;
      n_cycles = 65535 - int'(exp_cnt) + 5;
      repeat (n_cycles) @(posedge CLK);
    end
    #1;
    check("sat.stall_cnt", {16'd0, STALL_CNT}, 32'h0000_FFFF);
    check("sat.valid", {31'd0, EX_VALID}, 32'd0);
    exp_cnt = 16'hFFFF;
    $display("txn saturate: stall_cnt=%0d", STALL_CNT);

    set_mem(0, 0, 0);
    check_ready("sat_accept", 1'b1);
    push_ex("sat_accept", 32'd1, 32'd0, 3'd0, 5'd14, 1, 0);
    tick();
`else
    drive_id(1, 5'd1, 32'd9, 5'd2, 32'd11, 0, 0, 3'd6, 5'd14, 1, 0);
    check_ready("pre_rst", 1'b1);
    push_ex("pre_rst", 32'd9, 32'd11, 3'd6, 5'd14, 1, 0);
    tick();
`endif

    // Reset with a valid instruction in EX wins over everything
    RST = 1'b1;
    FLUSH = 1'b1;
    drive_id(1, 5'd2, 32'd9, 5'd0, 0, 0, 0, 3'd5, 5'd3, 1, 1);
    check_ready("final_rst", 1'b0);
    exp_cnt = 16'd0;
    push_full("final_rst", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    tick();

    RST = 1'b0;
    FLUSH = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_bubble("post_rst", 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
